data_sram_bridge: RTL and testbench

- Sits between the CPU data-memory port and an external asynchronous SRAM.
- Converts the CPU's single-cycle request (address, write data, read enable, write enable, byte mask) into timed SRAM read and write cycles with programmable wait states.
- Stalls the pipeline until each access completes.
- Read data returns as a full 32-bit word; byte/halfword extraction and sign extension stay in the CPU.

---
 rtl/data_sram_bridge.sv | 166 ++++++++++++++++
 tb/tb_data_sram_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// CPU data port to asynchronous SRAM bridge: turns single-cycle requests into
// timed SRAM read/write cycles with programmable wait states and stalls the CPU.
module data_sram_bridge #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    input  logic                  cpu_re_i,
    input  logic                  cpu_we_i,
    input  logic [3:0]            cpu_mask_i,
    output logic [31:0]           cpu_data_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_data_o,
    input  logic [31:0]           sram_data_i,
    output logic                  sram_data_oe_o,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic [3:0]            sram_be_n_o
);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StWriteHold, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            mask_q, mask_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic [3:0]            be_n_q, be_n_d;
    logic                  doe_q, doe_d;
    logic                  stall_c;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_WIDTH+2], cpu_addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall_c = cpu_re_i | cpu_we_i;
                if (cpu_we_i) begin
                    if (cpu_mask_i != 4'b0000) begin
                        state_d = StWrite;
                        addr_d  = cpu_addr_i[ADDR_WIDTH+1:2];
                        wdata_d = cpu_data_i;
                        mask_d  = cpu_mask_i;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StDone;
                    end
                end else if (cpu_re_i) begin
                    state_d = StRead;
                    addr_d  = cpu_addr_i[ADDR_WIDTH+1:2];
                    cnt_d   = CntLoad;
                end
            end
            StRead: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    rdata_d = sram_data_i;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrite: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StWriteHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWriteHold: begin
                stall_c = 1'b1;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are decoded from the next state so every SRAM pin comes straight off a flop.
    always_comb begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        be_n_d = 4'hF;
        doe_d  = 1'b0;
        unique case (state_d)
            StRead: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'h0;
            end
            StWrite: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                be_n_d = ~mask_d;
                doe_d  = 1'b1;
            end
            StWriteHold: begin
                ce_n_d = 1'b0;
                be_n_d = ~mask_d;
                doe_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            rdata_q <= 32'd0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            doe_q   <= doe_d;
        end
    end

    assign stall_o        = rst ? 1'b0 : stall_c;
    assign cpu_data_o     = rdata_q;
    assign sram_addr_o    = addr_q;
    assign sram_data_o    = wdata_q;
    assign sram_data_oe_o = doe_q;
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_be_n_o    = be_n_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: behavioural SRAM, reference memory model,
// randomized CPU requests and a negedge monitor that checks each completed access.
module tb_data_sram_bridge;

    localparam int unsigned WAIT = 2;
    localparam int unsigned AW   = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cpu_addr_i, cpu_data_i, cpu_data_o;
    logic          cpu_re_i, cpu_we_i, stall_o;
    logic [3:0]    cpu_mask_i;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_data_o;
    logic [31:0]   sram_data_i = 32'h0BAD_F00D;
    logic          sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [3:0]    sram_be_n_o;

    always #5 clk = ~clk;

    data_sram_bridge #(.WAIT_CYCLES(WAIT), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_re_i       (cpu_re_i),
        .cpu_we_i       (cpu_we_i),
        .cpu_mask_i     (cpu_mask_i),
        .cpu_data_o     (cpu_data_o),
        .stall_o        (stall_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o),
        .sram_be_n_o    (sram_be_n_o)
    );

    typedef struct {
        logic [31:0] rdata;
        int          stall;
        int          ce;
        int          oe;
        int          we;
        int          doe;
        logic [19:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] last_rd = 32'd0;
    int          checks = 0;
    int          passed = 0;
    bit          alive = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be_n);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (!be_n[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Asynchronous SRAM: writes commit on the rising edge of we_n.
    initial begin
        logic prev_we_n;
        prev_we_n = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_we_n == 1'b0 && sram_we_n_o == 1'b1)
                sram_mem[sram_addr_o[7:0]] = merge(sram_mem[sram_addr_o[7:0]], sram_data_o,
                                                   sram_be_n_o);
            prev_we_n   = sram_we_n_o;
            sram_data_i = (!sram_oe_n_o && !sram_ce_n_o) ? sram_mem[sram_addr_o[7:0]]
                                                         : 32'h0BAD_F00D;
        end
    end

    // Monitor: accumulates bus activity, pops an expectation when an access completes.
    initial begin
        int stall_cnt, ce_cnt, oe_cnt, we_cnt, doe_cnt;
        logic [19:0] addr_seen;
        logic contention;
        exp_t e;
        stall_cnt = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
        addr_seen = '0; contention = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
                contention = 1'b0;
            end else begin
                if (!sram_ce_n_o) begin
                    ce_cnt++;
                    addr_seen = sram_addr_o;
                end
                if (!sram_oe_n_o) oe_cnt++;
                if (!sram_we_n_o) we_cnt++;
                if (sram_data_oe_o) doe_cnt++;
                if (sram_data_oe_o && !sram_oe_n_o) contention = 1'b1;
                if (cpu_re_i || cpu_we_i) begin
                    if (stall_o) stall_cnt++;
                    else if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("cpu_data_o", cpu_data_o, e.rdata);
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                        check("ce_n_low_cycles", 32'(ce_cnt), 32'(e.ce));
                        check("oe_n_low_cycles", 32'(oe_cnt), 32'(e.oe));
                        check("we_n_low_cycles", 32'(we_cnt), 32'(e.we));
                        check("data_oe_cycles", 32'(doe_cnt), 32'(e.doe));
                        check("oe_vs_data_oe_overlap", 32'(contention), 32'd0);
                        if (e.ce != 0) check("sram_addr_o", 32'(addr_seen), 32'(e.addr));
                    end
                    if (!stall_o) begin
                        stall_cnt = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
                        contention = 1'b0;
                    end
                end
            end
        end
    end

    // Issues one request, records its expected outcome, returns in the DONE cycle.
    task automatic issue(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
        exp_t e;
        logic [19:0] wa;
        bit ok;
        if (!alive) return;
        wa = addr[21:2];
        @(posedge clk);
        #1;
        cpu_re_i = re; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data;
        cpu_mask_i = mask;
        e.addr = wa; e.oe = 0; e.we = 0; e.doe = 0; e.ce = 0;
        if (we) begin
            if (mask != 4'b0000) begin
                ref_mem[wa[7:0]] = merge(ref_mem[wa[7:0]], data, ~mask);
                e.stall = WAIT + 2; e.ce = WAIT + 1; e.we = WAIT; e.doe = WAIT + 1;
            end else begin
                e.stall = 1;
            end
        end else begin
            last_rd = ref_mem[wa[7:0]];
            e.stall = WAIT + 1; e.ce = WAIT; e.oe = WAIT;
        end
        e.rdata = last_rd;
        exp_q.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL req_timeout: stall_o still 1 after 40 cycles, required 0");
            alive = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        cpu_re_i = 1'b0; cpu_we_i = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        int op;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        sram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        rst = 1'b1; cpu_re_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = 32'd0; cpu_data_i = 32'd0; cpu_mask_i = 4'd0;

        #12;
        check("rst_ce_n", 32'(sram_ce_n_o), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n_o), 32'd1);
        check("rst_we_n", 32'(sram_we_n_o), 32'd1);
        check("rst_be_n", 32'(sram_be_n_o), 32'hF);
        check("rst_data_oe", 32'(sram_data_oe_o), 32'd0);
        check("rst_addr", 32'(sram_addr_o), 32'd0);
        check("rst_sram_data", sram_data_o, 32'd0);
        check("rst_cpu_data", cpu_data_o, 32'd0);
        cpu_re_i = 1'b1; cpu_we_i = 1'b1;
        #1;
        check("rst_stall_forced_low", 32'(stall_o), 32'd0);
        cpu_re_i = 1'b0; cpu_we_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios
        issue(1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'h0);
        issue(1'b0, 1'b1, 32'h0000_0008, 32'h00AB_0000, 4'b0100);
        issue(1'b1, 1'b0, 32'h0000_0008, 32'd0, 4'h0);
        issue(1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0);
        issue(1'b1, 1'b0, 32'h0000_0030, 32'd0, 4'h0);
        issue(1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF);
        issue(1'b1, 1'b0, 32'h0000_0014, 32'd0, 4'h0);
        idle(2);
        issue(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'h0);
        issue(1'b0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 4'hF);
        issue(1'b1, 1'b0, 32'h0000_0104, 32'd0, 4'h0);
        idle(1);

        // Randomized traffic; upper and lowest address bits are noise the DUT must ignore.
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            a[21:2] = 20'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) a[21:2] = 20'($urandom_range(0, 255));
            d = $urandom;
            op = $urandom_range(0, 9);
            if (op < 4)       issue(1'b1, 1'b0, a, d, 4'h0);
            else if (op < 8)  issue(1'b0, 1'b1, a, d, 4'($urandom_range(1, 15)));
            else if (op == 8) issue(1'b0, 1'b1, a, d, 4'h0);
            else              issue(1'b1, 1'b1, a, d, 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(1);

        // Reset during the first READ cycle abandons the access without a clock edge.
        @(posedge clk);
        #1;
        cpu_re_i = 1'b1; cpu_addr_i = 32'h0000_0020;
        @(posedge clk);
        #2;
        check("pre_rst_ce_n_active", 32'(sram_ce_n_o), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_ce_n", 32'(sram_ce_n_o), 32'd1);
        check("midrst_oe_n", 32'(sram_oe_n_o), 32'd1);
        check("midrst_cpu_data", cpu_data_o, 32'd0);
        check("midrst_stall", 32'(stall_o), 32'd0);
        cpu_re_i = 1'b0;
        last_rd = 32'd0;
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 32'(stall_o), 32'd0);
        check("post_rst_ce_n", 32'(sram_ce_n_o), 32'd1);
        issue(1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'h0);
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
